ps2_key_sequencer: RTL and testbench

Sequences raw PS/2 set-2 scan bytes from the keyboard receiver into ASCII characters for the terminal. It tracks make/break/extended prefixes, Shift and Caps Lock state, and drives the combinational scan-code-to-ASCII lookup through an external lookup port. Results are buffered in a 4-entry FIFO with a valid/ready handshake toward the terminal text engine.

---
 rtl/ps2_key_sequencer.sv | 145 ++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 scan byte sequencer: tracks prefixes and modifiers, drives an external
// scan-code-to-ASCII lookup, and buffers characters in a small valid/ready FIFO.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_byte,
  input  logic       scan_valid,
  output logic [7:0] lookup_code,
  output logic       lookup_case,
  input  logic [7:0] lookup_ascii,
  output logic [7:0] ascii_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       caps_lock,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             shift_l_q, shift_l_d;
  logic             shift_r_q, shift_r_d;
  logic             caps_q, caps_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       code_q, code_d;
  logic             case_q, case_d;
  logic             emit_pend_q, emit_pend_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       mem [FIFO_DEPTH];

  logic full, do_pop, do_push, drop;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    code_d      = code_q;
    case_d      = case_q;
    emit_pend_d = 1'b0;
    if (scan_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_byte == 8'hE0)      state_d = ST_EXT;
          else if (scan_byte == 8'hF0) state_d = ST_BRK;
          else begin
            unique case (scan_byte)
              8'h12:        shift_l_d = 1'b1;
              8'h59:        shift_r_d = 1'b1;
              8'h58:        caps_d    = ~caps_q;
              8'h14, 8'h11: ;
              default:      emit_pend_d = 1'b1;
            endcase
          end
        end
        ST_BRK: begin
          if (scan_byte == 8'h12) shift_l_d = 1'b0;
          if (scan_byte == 8'h59) shift_r_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (scan_byte == 8'hF0) state_d = ST_EXT_BRK;
          else begin
            if (scan_byte == 8'h5A || scan_byte == 8'h4A) emit_pend_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Case comes from the modifier state before this byte was applied.
    if (emit_pend_d) begin
      code_d = scan_byte;
      case_d = (shift_l_q | shift_r_q) ^ caps_q;
    end
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = ascii_valid & ascii_ready;
  assign do_push = emit_pend_q & (~full | do_pop);
  assign drop    = emit_pend_q & full & ~do_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      ovf_q       <= 1'b0;
      code_q      <= 8'h00;
      case_q      <= 1'b0;
      emit_pend_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      ovf_q       <= ovf_d;
      code_q      <= code_d;
      case_q      <= case_d;
      emit_pend_q <= emit_pend_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once written, and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= lookup_ascii;
  end

  assign ascii_valid = (count_q != '0);
  assign ascii_data  = ascii_valid ? mem[rd_ptr_q] : 8'h00;
  assign lookup_code = code_q;
  assign lookup_case = case_q;
  assign caps_lock   = caps_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: drives scan bytes, models the lookup ROM, and
// scoreboards characters popped from the FIFO against expected ASCII.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic [7:0] lookup_code;
  logic       lookup_case;
  logic [7:0] lookup_ascii;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       caps_lock;
  logic       overflow;
  logic       ovf_clr;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_key_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .lookup_code(lookup_code), .lookup_case(lookup_case), .lookup_ascii(lookup_ascii),
    .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .caps_lock(caps_lock), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // External lookup table for the handful of keys exercised here.
  function automatic logic [7:0] rom(input logic [7:0] code, input logic up);
    case (code)
      8'h1C:   return up ? 8'h41 : 8'h61;
      8'h32:   return up ? 8'h42 : 8'h62;
      8'h21:   return up ? 8'h43 : 8'h63;
      8'h23:   return up ? 8'h44 : 8'h64;
      8'h24:   return up ? 8'h45 : 8'h65;
      8'h2B:   return up ? 8'h46 : 8'h66;
      8'h16:   return up ? 8'h21 : 8'h31;
      8'h5A:   return 8'h0A;
      8'h4A:   return 8'h2F;
      default: return 8'h3F;
    endcase
  endfunction

  always_comb lookup_ascii = rom(lookup_code, lookup_case);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every accepted character must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ascii_valid && ascii_ready) begin
      if (exp_q.size() == 0) check("extra_char", 32'(ascii_data), 32'h100);
      else check("char", 32'(ascii_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; consecutive calls give back-to-back bytes.
  task automatic send(input logic [7:0] b);
    scan_byte  = b;
    scan_valid = 1'b1;
    step();
    scan_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    ascii_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    check({tag, "_empty"}, 32'(ascii_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(ascii_valid), 32'd0);
    check({tag, "_data"},  32'(ascii_data),  32'h00);
    check({tag, "_code"},  32'(lookup_code), 32'h00);
    check({tag, "_case"},  32'(lookup_case), 32'd0);
    check({tag, "_caps"},  32'(caps_lock),   32'd0);
    check({tag, "_ovf"},   32'(overflow),    32'd0);
  endtask

  initial begin
    reset = 1'b1; scan_byte = 8'h00; scan_valid = 1'b0;
    ascii_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Press 'a': latency and handshake.
    exp_q.push_back(8'h61);
    send(8'h1C);
    check("a_code", 32'(lookup_code), 32'h1C);
    check("a_case", 32'(lookup_case), 32'd0);
    check("a_valid_n1", 32'(ascii_valid), 32'd0);
    step();
    check("a_valid_n2", 32'(ascii_valid), 32'd1);
    check("a_data_n2", 32'(ascii_data), 32'h61);
    ascii_ready = 1'b1;
    step();
    check("a_popped", 32'(ascii_valid), 32'd0);

    // Shift press/release around an 'a'.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h61);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    drain("shift");

    // Caps Lock toggling.
    send(8'h58);
    check("caps_on", 32'(caps_lock), 32'd1);
    send(8'hF0); send(8'h58);
    check("caps_held", 32'(caps_lock), 32'd1);
    exp_q.push_back(8'h21);
    send(8'h16);
    check("caps_case", 32'(lookup_case), 32'd1);
    drain("caps");
    send(8'h58);
    check("caps_off", 32'(caps_lock), 32'd0);

    // Extended keys: keypad Enter and / emit, others ignored, FSM returns to IDLE.
    exp_q.push_back(8'h0A);
    send(8'hE0); send(8'h5A);
    check("ext_code", 32'(lookup_code), 32'h5A);
    exp_q.push_back(8'h2F);
    send(8'hE0); send(8'h4A);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_q.push_back(8'h61);
    send(8'h1C);
    drain("ext");

    // Overflow: five back-to-back makes into a stalled four-entry FIFO.
    ascii_ready = 1'b0;
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h63); exp_q.push_back(8'h64);
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(ascii_data), 32'h61);

    // A drop coinciding with ovf_clr keeps overflow set.
    send(8'h2C);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push and pop in the same cycle while full: nothing is lost.
    exp_q.push_back(8'h66);
    send(8'h2B);
    ascii_ready = 1'b1;
    step();
    ascii_ready = 1'b0;
    step();
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_head", 32'(ascii_data), 32'h62);
    drain("ovf");

    // Reset after a break prefix flushes everything.
    ascii_ready = 1'b0;
    send(8'h58);
    send(8'h1C);
    send(8'hF0);
    reset = 1'b1;
    step(); step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    step();
    exp_q.push_back(8'h61);
    send(8'h1C);
    drain("postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
